// File: rtl/my_pkg.sv
// Shared types for the execute/writeback path: unit identifiers, writeback
// queue entry layout and the hard-wired zero register.
package my_pkg;

    typedef enum logic [1:0] {
        UNIT_LOGIC = 2'd0,
        UNIT_ADD   = 2'd1,
        UNIT_SHIFT = 2'd2,
        UNIT_RSVD  = 2'd3
    } unit_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Show-ahead FIFO with synchronous reset and occupancy output.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = push & ~w_full;
    assign w_pop   = pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign valid = ~w_empty;
    assign count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/exec_writeback_collector.sv
// Books each issued op's writeback slot by unit latency, captures the unit result
// on the cycle it emerges and queues {rd, data} for the register file.
module exec_writeback_collector
    import my_pkg::*;
#(
    parameter int unsigned LAT_LOGIC  = 3,
    parameter int unsigned LAT_ADD    = 2,
    parameter int unsigned LAT_SHIFT  = 1,
    parameter int unsigned MAX_LAT    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_unit,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] logic_result,
    input  logic [31:0] adder_result,
    input  logic [31:0] shift_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  inflight
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [MAX_LAT:1] r_resv;
    logic [MAX_LAT:1] w_resv_sh;
    logic [MAX_LAT:1] w_lat_oh;
    logic [4:0]       r_trk_rd      [1:MAX_LAT];
    logic [4:0]       w_trk_rd_sh   [1:MAX_LAT];
    unit_e            r_trk_unit    [1:MAX_LAT];
    unit_e            w_trk_unit_sh [1:MAX_LAT];
    logic [3:0]       r_inflight;

    unit_e            w_unit;
    int unsigned      w_lat;
    logic             w_slot_busy;
    logic [31:0]      w_used;
    logic             w_book;
    logic             w_cap;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_cap_data;
    wb_entry_t        w_push_entry;
    wb_entry_t        w_head;
    logic             w_fifo_valid;
    logic [CW-1:0]    w_fifo_count;

    assign w_unit = unit_e'(issue_unit);

    // Reserved unit id follows the LOGIC latency for slot checking.
    always_comb begin
        w_lat    = LAT_LOGIC;
        w_lat_oh = '0;
        case (w_unit)
            UNIT_ADD:   w_lat = LAT_ADD;
            UNIT_SHIFT: w_lat = LAT_SHIFT;
            default:    w_lat = LAT_LOGIC;
        endcase
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            w_lat_oh[k] = (k == w_lat);
        end
    end

    always_comb begin
        w_resv_sh              = {1'b0, r_resv[MAX_LAT:2]};
        w_trk_rd_sh[MAX_LAT]   = REG_ZERO;
        w_trk_unit_sh[MAX_LAT] = UNIT_LOGIC;
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            w_trk_rd_sh[k]   = r_trk_rd[k+1];
            w_trk_unit_sh[k] = r_trk_unit[k+1];
        end
    end

    // Credit counts only registered occupancy; a pop this cycle is not credited.
    assign w_slot_busy = |(w_resv_sh & w_lat_oh);
    assign w_used      = 32'(r_inflight) + 32'(w_fifo_count);
    assign issue_ready = ~reset & ~w_slot_busy & (w_used < FIFO_DEPTH);
    assign w_book      = issue_valid & issue_ready & (w_unit != UNIT_RSVD);

    assign w_cap = r_resv[1];

    always_comb begin
        w_cap_data = logic_result;
        case (r_trk_unit[1])
            UNIT_ADD:   w_cap_data = adder_result;
            UNIT_SHIFT: w_cap_data = shift_result;
            default:    w_cap_data = logic_result;
        endcase
    end

    assign w_push       = w_cap & (r_trk_rd[1] != REG_ZERO);
    assign w_push_entry = '{rd: r_trk_rd[1], data: w_cap_data};
    assign w_pop        = w_fifo_valid & wb_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resv     <= '0;
            r_inflight <= '0;
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                r_trk_rd[k]   <= REG_ZERO;
                r_trk_unit[k] <= UNIT_LOGIC;
            end
        end else begin
            r_resv <= w_resv_sh | (w_book ? w_lat_oh : '0);
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                if (w_book && w_lat_oh[k]) begin
                    r_trk_rd[k]   <= issue_rd;
                    r_trk_unit[k] <= w_unit;
                end else begin
                    r_trk_rd[k]   <= w_trk_rd_sh[k];
                    r_trk_unit[k] <= w_trk_unit_sh[k];
                end
            end
            case ({w_book, w_cap})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_pop),
        .dout  (w_head),
        .valid (w_fifo_valid),
        .count (w_fifo_count)
    );

    assign wb_valid = w_fifo_valid & ~reset;
    assign wb_rd    = reset ? REG_ZERO : w_head.rd;
    assign wb_data  = reset ? '0 : w_head.data;
    assign inflight = reset ? '0 : r_inflight;

endmodule
